// File: rtl/mfp_spi_rx_pkg.sv
// Shared types and build defaults for the mfp_spi_rx SPI receive endpoint.
package mfp_spi_rx_pkg;

  // Default word width and queue depth for the receive endpoint.
  localparam int unsigned MFP_SPI_RX_DATA_W = 8;
  localparam int unsigned MFP_SPI_RX_DEPTH  = 4;

  // Receive state machine encoding.
  typedef enum logic {
    RX_IDLE  = 1'b0,
    RX_SHIFT = 1'b1
  } rx_state_e;

endpackage

// File: rtl/mfp_spi_rx_sync.sv
// Two-flop synchronizer for one asynchronous input.
// Resets asynchronously to RST_VAL so an idle line reads as its inactive level.
module mfp_spi_rx_sync #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mfp_spi_rx.sv
// SPI mode-0 receive endpoint. Oversamples SCLK/CS_N/MOSI in the ahbCLK
// domain, deserializes MSB-first words and queues them for the processor
// through the IO_READ_RDY / IO_READ_ACK handshake.
// Build option: define MFP_SPI_RX_FIFO_EN for a DEPTH-entry circular FIFO;
// otherwise a single holding register is used and DEPTH is ignored.
module mfp_spi_rx
  import mfp_spi_rx_pkg::*;
#(
  parameter int unsigned DATA_W = MFP_SPI_RX_DATA_W,
  parameter int unsigned DEPTH  = MFP_SPI_RX_DEPTH
) (
  input  logic              ahbCLK,
  input  logic              resetN,
  input  logic              SCLK,
  input  logic              CS_N,
  input  logic              MOSI,
  output logic [DATA_W-1:0] IO_RX_DATA,
  output logic              IO_READ_RDY,
  input  logic              IO_READ_ACK,
  output logic              IO_RX_OVR,
  input  logic              IO_RX_CLR
);

`ifdef MFP_SPI_RX_FIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif

  // Effective queue depth: the holding-register build behaves as depth 1.
  localparam int unsigned Q_DEPTH = FIFO_EN ? DEPTH : 1;
  localparam int unsigned CNT_W   = $clog2(Q_DEPTH) + 1;
  localparam int unsigned BIT_W   = $clog2(DATA_W) + 1;

  // ---------------------------------------------------------------------
  // Input synchronization and SCLK rising-edge detection
  // ---------------------------------------------------------------------
  logic sclk_sync;
  logic cs_sync;
  logic mosi_sync;
  logic sclk_dly_q;
  logic sclk_rise;

  mfp_spi_rx_sync #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk_i  (ahbCLK),
    .rst_ni (resetN),
    .d_i    (SCLK),
    .q_o    (sclk_sync)
  );

  mfp_spi_rx_sync #(.RST_VAL(1'b1)) u_sync_cs (
    .clk_i  (ahbCLK),
    .rst_ni (resetN),
    .d_i    (CS_N),
    .q_o    (cs_sync)
  );

  mfp_spi_rx_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk_i  (ahbCLK),
    .rst_ni (resetN),
    .d_i    (MOSI),
    .q_o    (mosi_sync)
  );

  // Delayed copy of the synchronized serial clock for edge detection.
  always_ff @(posedge ahbCLK or negedge resetN) begin
    if (!resetN) begin
      sclk_dly_q <= 1'b0;
    end else begin
      sclk_dly_q <= sclk_sync;
    end
  end

  assign sclk_rise = sclk_sync & ~sclk_dly_q;

  // ---------------------------------------------------------------------
  // Receive state machine / deserializer
  // ---------------------------------------------------------------------
  rx_state_e         state_q, state_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-2:0] shift_q, shift_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              push_q, push_d;
  logic [DATA_W-1:0] shifted;

  // Deserializer state registers; push_q is a one-cycle strobe.
  always_ff @(posedge ahbCLK or negedge resetN) begin
    if (!resetN) begin
      state_q   <= RX_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      word_q    <= '0;
      push_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      word_q    <= word_d;
      push_q    <= push_d;
    end
  end

  // Next-state logic: shift on each SCLK rise, emit a word every DATA_W bits,
  // abandon any partial word when chip select goes inactive.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    word_d    = word_q;
    push_d    = 1'b0;
    shifted   = {shift_q, mosi_sync};
    case (state_q)
      RX_IDLE: begin
        bit_cnt_d = '0;
        if (!cs_sync) begin
          state_d = RX_SHIFT;
        end
      end
      RX_SHIFT: begin
        if (cs_sync) begin
          state_d   = RX_IDLE;
          bit_cnt_d = '0;
        end else if (sclk_rise) begin
          shift_d = shifted[DATA_W-2:0];
          if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
            bit_cnt_d = '0;
            word_d    = shifted;
            push_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d   = RX_IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Receive queue: occupancy, overrun and handshake
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovr_q, ovr_d;
  logic              q_full;
  logic              q_empty;
  logic              pop;
  logic              wr_en;
  logic              ovr_set;
  logic [DATA_W-1:0] head;

  assign q_full  = (cnt_q == CNT_W'(Q_DEPTH));
  assign q_empty = (cnt_q == '0);
  // A pop on an empty queue is ignored entirely.
  assign pop     = IO_READ_ACK & ~q_empty;
  // A simultaneous pop frees the slot, so a push into a full queue still lands.
  assign wr_en   = push_q & (~q_full | pop);
  assign ovr_set = push_q & q_full & ~pop;

  // Occupancy and sticky-overrun registers.
  always_ff @(posedge ahbCLK or negedge resetN) begin
    if (!resetN) begin
      cnt_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovr_q <= ovr_d;
    end
  end

  // Occupancy update; overrun set takes priority over clear.
  always_comb begin
    cnt_d = cnt_q;
    if (wr_en && !pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!wr_en && pop) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    ovr_d = ovr_q;
    if (ovr_set) begin
      ovr_d = 1'b1;
    end else if (IO_RX_CLR) begin
      ovr_d = 1'b0;
    end
  end

  generate
    if (Q_DEPTH > 1) begin : g_fifo
      localparam int unsigned AW = $clog2(Q_DEPTH);

      logic [DATA_W-1:0] mem_q [Q_DEPTH];
      logic [AW-1:0]     wr_ptr_q;
      logic [AW-1:0]     rd_ptr_q;

      // Circular pointers; power-of-two depth makes the wrap implicit.
      always_ff @(posedge ahbCLK or negedge resetN) begin
        if (!resetN) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
        end else begin
          if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
          end
          if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
          end
        end
      end

      // Storage array; contents need no reset because occupancy gates them.
      always_ff @(posedge ahbCLK) begin
        if (wr_en) begin
          mem_q[wr_ptr_q] <= word_q;
        end
      end

      assign head = mem_q[rd_ptr_q];
    end else begin : g_hold
      logic [DATA_W-1:0] hold_q;

      // Single holding register loaded on every accepted push.
      always_ff @(posedge ahbCLK or negedge resetN) begin
        if (!resetN) begin
          hold_q <= '0;
        end else if (wr_en) begin
          hold_q <= word_q;
        end
      end

      assign head = hold_q;
    end
  endgenerate

  assign IO_RX_DATA  = q_empty ? '0 : head;
  assign IO_READ_RDY = ~q_empty;
  assign IO_RX_OVR   = ovr_q;

endmodule

// File: tb/tb_mfp_spi_rx.sv
// Directed bench for mfp_spi_rx. Adapts the queue-depth expectations to the
// build option MFP_SPI_RX_FIFO_EN (4 entries when defined, 1 otherwise).
module tb_mfp_spi_rx;

`ifdef MFP_SPI_RX_FIFO_EN
  localparam int QD = 4;
`else
  localparam int QD = 1;
`endif

  logic       ahbCLK = 1'b0;
  logic       resetN;
  logic       SCLK;
  logic       CS_N;
  logic       MOSI;
  logic [7:0] IO_RX_DATA;
  logic       IO_READ_RDY;
  logic       IO_READ_ACK;
  logic       IO_RX_OVR;
  logic       IO_RX_CLR;

  int n_checks = 0;
  int n_pass   = 0;

  mfp_spi_rx #(.DATA_W(8), .DEPTH(4)) dut (
    .ahbCLK      (ahbCLK),
    .resetN      (resetN),
    .SCLK        (SCLK),
    .CS_N        (CS_N),
    .MOSI        (MOSI),
    .IO_RX_DATA  (IO_RX_DATA),
    .IO_READ_RDY (IO_READ_RDY),
    .IO_READ_ACK (IO_READ_ACK),
    .IO_RX_OVR   (IO_RX_OVR),
    .IO_RX_CLR   (IO_RX_CLR)
  );

  always #5 ahbCLK = ~ahbCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
      $display("check %s: got %0h expected %0h ok", tag, obs, exp);
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One SCLK period of ahbCLK/8: 4 cycles low with MOSI set, then 4 cycles high.
  task automatic send_bit(input logic b);
    @(negedge ahbCLK);
    MOSI = b;
    SCLK = 1'b0;
    repeat (4) @(negedge ahbCLK);
    SCLK = 1'b1;
    repeat (4) @(negedge ahbCLK);
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  // Sends bits 7..1, then raises SCLK for bit 0 and returns at that instant.
  task automatic send_upto_last(input logic [7:0] w);
    for (int i = 7; i >= 1; i--) send_bit(w[i]);
    @(negedge ahbCLK);
    MOSI = w[0];
    SCLK = 1'b0;
    repeat (4) @(negedge ahbCLK);
    SCLK = 1'b1;
  endtask

  task automatic start_frame();
    @(negedge ahbCLK);
    SCLK = 1'b0;
    CS_N = 1'b0;
    repeat (4) @(negedge ahbCLK);
  endtask

  task automatic end_frame();
    @(negedge ahbCLK);
    SCLK = 1'b0;
    repeat (2) @(negedge ahbCLK);
    CS_N = 1'b1;
    repeat (6) @(negedge ahbCLK);
  endtask

  task automatic pop();
    @(negedge ahbCLK);
    IO_READ_ACK = 1'b1;
    @(negedge ahbCLK);
    IO_READ_ACK = 1'b0;
  endtask

  task automatic read_expect(input string tag, input logic [7:0] exp);
    chk({tag, "_rdy"}, {31'd0, IO_READ_RDY}, 32'd1);
    chk({tag, "_data"}, {24'd0, IO_RX_DATA}, {24'd0, exp});
    pop();
  endtask

  task automatic expect_empty(input string tag);
    chk({tag, "_rdy"}, {31'd0, IO_READ_RDY}, 32'd0);
    chk({tag, "_data"}, {24'd0, IO_RX_DATA}, 32'd0);
  endtask

  initial begin
    resetN      = 1'b1;
    SCLK        = 1'b0;
    CS_N        = 1'b1;
    MOSI        = 1'b0;
    IO_READ_ACK = 1'b0;
    IO_RX_CLR   = 1'b0;
    #2 resetN = 1'b0;
    repeat (3) @(negedge ahbCLK);
    expect_empty("reset");
    chk("reset_ovr", {31'd0, IO_RX_OVR}, 32'd0);
    resetN = 1'b1;
    repeat (3) @(negedge ahbCLK);

    // Single word 0xA5 with latency check around the final SCLK rise.
    start_frame();
    send_upto_last(8'hA5);
    @(posedge ahbCLK);          // edge k
    @(posedge ahbCLK);          // edge k+1
    @(posedge ahbCLK); #1;      // edge k+2
    chk("lat_k2_rdy", {31'd0, IO_READ_RDY}, 32'd0);
    @(posedge ahbCLK); #1;      // edge k+3
    chk("lat_k3_rdy", {31'd0, IO_READ_RDY}, 32'd1);
    chk("lat_k3_data", {24'd0, IO_RX_DATA}, 32'hA5);
    repeat (4) @(negedge ahbCLK);
    end_frame();
    pop();
    expect_empty("a5_popped");

    // ACK while empty is ignored: a later word is delivered and one pop empties.
    pop();
    expect_empty("ack_empty");
    start_frame();
    send_word(8'h96);
    end_frame();
    read_expect("after_idle_ack", 8'h96);
    expect_empty("after_idle_ack_empty");

    // Back-to-back words filling the queue exactly, no overrun.
    start_frame();
    for (int i = 1; i <= QD; i++) send_word(8'(i));
    end_frame();
    chk("fill_ovr", {31'd0, IO_RX_OVR}, 32'd0);
    for (int i = 1; i <= QD; i++) read_expect($sformatf("fill_%0d", i), 8'(i));
    expect_empty("fill_empty");

    // One word more than the queue holds: last word dropped, overrun set.
    start_frame();
    for (int i = 1; i <= QD + 1; i++) send_word(8'(i));
    end_frame();
    chk("ovr_set", {31'd0, IO_RX_OVR}, 32'd1);
    for (int i = 1; i <= QD; i++) read_expect($sformatf("ovr_rd_%0d", i), 8'(i));
    expect_empty("ovr_empty");
    chk("ovr_sticky", {31'd0, IO_RX_OVR}, 32'd1);
    @(negedge ahbCLK);
    IO_RX_CLR = 1'b1;
    @(negedge ahbCLK);
    IO_RX_CLR = 1'b0;
    chk("ovr_clr", {31'd0, IO_RX_OVR}, 32'd0);

    // Full queue: push of 0x55 coincides with an ACK -> both happen.
    start_frame();
    for (int i = 0; i < QD; i++) send_word(8'(8'h11 + i));
    send_upto_last(8'h55);
    @(posedge ahbCLK);          // edge k
    @(posedge ahbCLK);          // edge k+1
    @(posedge ahbCLK); #1;      // edge k+2
    IO_READ_ACK = 1'b1;
    @(posedge ahbCLK); #1;      // edge k+3: push and pop together
    IO_READ_ACK = 1'b0;
    repeat (4) @(negedge ahbCLK);
    end_frame();
    chk("pushpop_ovr", {31'd0, IO_RX_OVR}, 32'd0);
    for (int i = 1; i < QD; i++) read_expect($sformatf("pushpop_%0d", i), 8'(8'h11 + i));
    read_expect("pushpop_last", 8'h55);
    expect_empty("pushpop_empty");

    // Partial word aborted by CS_N, then a full 0x3C.
    start_frame();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    end_frame();
    expect_empty("abort_none");
    start_frame();
    send_word(8'h3C);
    end_frame();
    read_expect("abort_3c", 8'h3C);
    expect_empty("abort_empty");

    // Reset mid-word with a full queue and overrun pending.
    start_frame();
    for (int i = 1; i <= QD + 1; i++) send_word(8'(8'h20 + i));
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    chk("prerst_rdy", {31'd0, IO_READ_RDY}, 32'd1);
    chk("prerst_ovr", {31'd0, IO_RX_OVR}, 32'd1);
    #2 resetN = 1'b0;
    #1;
    expect_empty("midrst");
    chk("midrst_ovr", {31'd0, IO_RX_OVR}, 32'd0);
    SCLK = 1'b0;
    CS_N = 1'b1;
    repeat (3) @(negedge ahbCLK);
    resetN = 1'b1;
    repeat (3) @(negedge ahbCLK);
    start_frame();
    send_word(8'h81);
    end_frame();
    read_expect("postrst_81", 8'h81);
    expect_empty("postrst_empty");
    chk("postrst_ovr", {31'd0, IO_RX_OVR}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
